cache_arbiter: RTL and testbench

Shares the single physical-memory port (the cacheline adaptor) between the instruction cache and the data cache of the pipelined RV32I core. Accepts one line-sized request at a time from either cache, latches its address and write data, drives the memory port until `pmem_resp`, and routes the response back to the requester. Ties between simultaneous requests are broken round-robin.

---
 rtl/cache_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Brief    : Round-robin arbiter sharing one line-sized memory port between
//            the I-cache and the D-cache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_grant;
  logic                    r_we;
  logic                    r_proto_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wdata;
  logic                    w_i_req;
  logic                    w_d_req;
  logic                    w_grant_i;
  logic                    w_grant_d;

  assign w_i_req = icache_read;
  assign w_d_req = dcache_read | dcache_write;

  // On a tie D wins unless it was the last side served, so ties alternate.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || !r_last_grant)) begin
          w_grant_d = 1'b1;
          w_next    = GRANT_D;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
          w_next    = GRANT_I;
        end
      end
      GRANT_I: if (pmem_resp) w_next = DONE;
      GRANT_D: if (pmem_resp) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_grant_i) begin
        r_addr       <= icache_address;
        r_last_grant <= 1'b0;
      end else if (w_grant_d) begin
        r_addr       <= dcache_address;
        r_wdata      <= dcache_wdata;
        r_we         <= dcache_write;
        r_last_grant <= 1'b1;
      end
      if (pmem_resp && (r_state == IDLE || r_state == DONE)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Strobes come straight from registered state so they cannot glitch.
  assign pmem_read    = (r_state == GRANT_I) || ((r_state == GRANT_D) && !r_we);
  assign pmem_write   = (r_state == GRANT_D) && r_we;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign icache_resp  = (r_state == GRANT_I) && pmem_resp;
  assign dcache_resp  = (r_state == GRANT_D) && pmem_resp;
  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Brief    : Directed vector bench for cache_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [LW-1:0] c_a = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] c_b = {8{32'hB00B_1234}};
  localparam logic [LW-1:0] c_c = {8{32'hC0DE_5678}};
  localparam logic [LW-1:0] c_d = {8{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .proto_err(proto_err)
  );

  typedef struct {
    logic          ird, drd, dwr;
    logic [AW-1:0] iaddr, daddr;
    logic [LW-1:0] wdata;
    logic          presp;
    logic [LW-1:0] prdata;
    logic          e_pr, e_pw, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    logic          e_perr;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic ird, input logic drd, input logic dwr,
                              input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                              input logic [LW-1:0] wdata, input logic presp,
                              input logic [LW-1:0] prdata,
                              input logic e_pr, input logic e_pw, input logic e_ir,
                              input logic e_dr, input logic [AW-1:0] e_addr,
                              input logic [LW-1:0] e_wdata, input logic e_perr);
    vec_t v;
    v.ird = ird; v.drd = drd; v.dwr = dwr; v.iaddr = iaddr; v.daddr = daddr;
    v.wdata = wdata; v.presp = presp; v.prdata = prdata;
    v.e_pr = e_pr; v.e_pw = e_pw; v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ird, input logic drd, input logic dwr,
                       input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                       input logic [LW-1:0] wdata, input logic presp,
                       input logic [LW-1:0] prdata);
    icache_read = ird; dcache_read = drd; dcache_write = dwr;
    icache_address = iaddr; dcache_address = daddr; dcache_wdata = wdata;
    pmem_resp = presp; pmem_rdata = prdata;
  endtask

  task automatic chk_strobes(input string tag, input logic pr, input logic pw,
                             input logic ir, input logic dr);
    chk({tag, ".pmem_read"},   {255'd0, pmem_read},   {255'd0, pr});
    chk({tag, ".pmem_write"},  {255'd0, pmem_write},  {255'd0, pw});
    chk({tag, ".icache_resp"}, {255'd0, icache_resp}, {255'd0, ir});
    chk({tag, ".dcache_resp"}, {255'd0, dcache_resp}, {255'd0, dr});
  endtask

  initial begin
    // Continuous sequence starting from reset: lone I-fill, lone D-writeback,
    // tie with last grant D, D read, read+write treated as write, stray resp.
    tbl[0]  = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h0000, '0,  0);
    tbl[1]  = mk(1,0,0, 32'h60, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h0000, '0,  0);
    tbl[2]  = mk(1,0,0, 32'h60, 32'h0000, '0,  0, '0,  1,0,0,0, 32'h0060, '0,  0);
    tbl[3]  = mk(1,0,0, 32'h80, 32'h0000, '0,  0, '0,  1,0,0,0, 32'h0060, '0,  0);
    tbl[4]  = mk(1,0,0, 32'h80, 32'h0000, '0,  0, '0,  1,0,0,0, 32'h0060, '0,  0);
    tbl[5]  = mk(1,0,0, 32'h80, 32'h0000, '0,  1, c_a, 1,0,1,0, 32'h0060, '0,  0);
    tbl[6]  = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h0060, '0,  0);
    tbl[7]  = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h0060, '0,  0);
    tbl[8]  = mk(0,0,1, 32'h00, 32'h1000, c_b, 0, '0,  0,0,0,0, 32'h0060, '0,  0);
    tbl[9]  = mk(0,0,1, 32'h00, 32'h1000, '0,  0, '0,  0,1,0,0, 32'h1000, c_b, 0);
    tbl[10] = mk(0,0,1, 32'h00, 32'h1000, '0,  1, '0,  0,1,0,1, 32'h1000, c_b, 0);
    tbl[11] = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h1000, c_b, 0);
    tbl[12] = mk(1,1,0, 32'h40, 32'h2000, '0,  0, '0,  0,0,0,0, 32'h1000, c_b, 0);
    tbl[13] = mk(1,1,0, 32'h40, 32'h2000, '0,  0, '0,  1,0,0,0, 32'h0040, c_b, 0);
    tbl[14] = mk(1,1,0, 32'h40, 32'h2000, '0,  1, c_a, 1,0,1,0, 32'h0040, c_b, 0);
    tbl[15] = mk(0,1,0, 32'h00, 32'h2000, '0,  0, '0,  0,0,0,0, 32'h0040, c_b, 0);
    tbl[16] = mk(0,1,0, 32'h00, 32'h2000, '0,  0, '0,  0,0,0,0, 32'h0040, c_b, 0);
    tbl[17] = mk(0,1,0, 32'h00, 32'h2000, '0,  0, '0,  1,0,0,0, 32'h2000, '0,  0);
    tbl[18] = mk(0,1,0, 32'h00, 32'h2000, '0,  1, c_c, 1,0,0,1, 32'h2000, '0,  0);
    tbl[19] = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h2000, '0,  0);
    tbl[20] = mk(0,1,1, 32'h00, 32'h3000, c_d, 0, '0,  0,0,0,0, 32'h2000, '0,  0);
    tbl[21] = mk(0,1,1, 32'h00, 32'h3000, '0,  0, '0,  0,1,0,0, 32'h3000, c_d, 0);
    tbl[22] = mk(0,1,1, 32'h00, 32'h3000, '0,  1, '0,  0,1,0,1, 32'h3000, c_d, 0);
    tbl[23] = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h3000, c_d, 0);
    tbl[24] = mk(0,0,0, 32'h00, 32'h0000, '0,  1, c_a, 0,0,0,0, 32'h3000, c_d, 0);
    tbl[25] = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h3000, c_d, 1);
    tbl[26] = mk(1,0,0, 32'h44, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h3000, c_d, 1);
    tbl[27] = mk(1,0,0, 32'h44, 32'h0000, '0,  0, '0,  1,0,0,0, 32'h0044, c_d, 1);
    tbl[28] = mk(0,0,0, 32'h00, 32'h0000, '0,  1, c_b, 1,0,1,0, 32'h0044, c_d, 1);
    tbl[29] = mk(0,0,0, 32'h00, 32'h0000, '0,  0, '0,  0,0,0,0, 32'h0044, c_d, 1);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.pmem_address", {224'd0, pmem_address}, '0);
    chk("reset.proto_err", {255'd0, proto_err}, '0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].ird, tbl[i].drd, tbl[i].dwr, tbl[i].iaddr, tbl[i].daddr,
            tbl[i].wdata, tbl[i].presp, tbl[i].prdata);
      #1;
      chk_strobes($sformatf("v%0d", i), tbl[i].e_pr, tbl[i].e_pw, tbl[i].e_ir, tbl[i].e_dr);
      chk($sformatf("v%0d.pmem_address", i), {224'd0, pmem_address}, {224'd0, tbl[i].e_addr});
      chk($sformatf("v%0d.pmem_wdata", i), pmem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d.proto_err", i), {255'd0, proto_err}, {255'd0, tbl[i].e_perr});
      if (tbl[i].e_ir) chk($sformatf("v%0d.icache_rdata", i), icache_rdata, tbl[i].prdata);
      if (tbl[i].e_dr) chk($sformatf("v%0d.dcache_rdata", i), dcache_rdata, tbl[i].prdata);
    end

    // Fresh reset clears the sticky error; first tie then goes to D.
    @(negedge clk);
    drive(0,0,0, '0, '0, '0, 0, '0);
    rst = 1'b0;
    #1;
    chk("rst2.proto_err", {255'd0, proto_err}, '0);
    chk("rst2.pmem_address", {224'd0, pmem_address}, '0);
    @(negedge clk);
    rst = 1'b1;
    drive(1,1,0, 32'h100, 32'h200, '0, 0, '0);
    @(negedge clk); #1;
    chk_strobes("tie1", 1,0,0,0);
    chk("tie1.addr", {224'd0, pmem_address}, {224'd0, 32'h200});
    @(negedge clk);
    drive(1,1,0, 32'h100, 32'h200, '0, 1, c_c); #1;
    chk_strobes("tie1.resp", 1,0,0,1);
    @(negedge clk);
    drive(1,0,0, 32'h100, 32'h000, '0, 0, '0);
    @(negedge clk);
    drive(1,1,0, 32'h100, 32'h300, '0, 0, '0);
    @(negedge clk); #1;
    chk_strobes("tie2", 1,0,0,0);
    chk("tie2.addr", {224'd0, pmem_address}, {224'd0, 32'h100});
    @(negedge clk);
    drive(1,1,0, 32'h100, 32'h300, '0, 1, c_a); #1;
    chk_strobes("tie2.resp", 1,0,1,0);
    @(negedge clk);
    drive(1,1,0, 32'h100, 32'h300, '0, 0, '0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("tie3.addr", {224'd0, pmem_address}, {224'd0, 32'h300});
    @(negedge clk);
    drive(0,1,0, 32'h000, 32'h300, '0, 1, c_c); #1;
    chk_strobes("tie3.resp", 1,0,0,1);

    // Asynchronous reset in the middle of a D writeback.
    @(negedge clk);
    drive(0,0,0, '0, '0, '0, 0, '0);
    @(negedge clk);
    drive(0,0,1, 32'h0, 32'h400, c_b, 0, '0);
    @(negedge clk); #1;
    chk_strobes("wb", 0,1,0,0);
    #2;
    rst = 1'b0;
    #1;
    chk_strobes("midrst", 0,0,0,0);
    pmem_resp = 1'b1;
    #1;
    chk("midrst.dcache_resp", {255'd0, dcache_resp}, '0);
    @(negedge clk);
    drive(1,0,0, 32'h500, 32'h0, '0, 0, '0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_strobes("after", 1,0,0,0);
    chk("after.addr", {224'd0, pmem_address}, {224'd0, 32'h500});
    @(negedge clk);
    drive(1,0,0, 32'h500, 32'h0, '0, 1, c_d); #1;
    chk_strobes("after.resp", 1,0,1,0);
    chk("after.rdata", icache_rdata, c_d);
    chk("after.proto_err", {255'd0, proto_err}, '0);
    @(negedge clk);
    drive(0,0,0, '0, '0, '0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
